sha256_msg_padder: RTL
======================

Name: sha256_msg_padder

Overview:
- Streaming SHA-256 message packer/padder. It accepts bytes from the UART/host side in configurable beat widths and emits big-endian 32-bit words to the SHA-256 core, one word per handshake.
- Unlike the single-block packer, it handles messages of any length and inserts FIPS 180-4 padding (0x80, zeros, 64-bit bit-length). It spans as many 512-bit blocks as needed and applies valid/ready back-pressure on both sides.
- Sits between the UART receiver and the sha256 core; drives block framing flags so the core knows when to re-init H and when the final digest is valid.

Parameters:
- IN_BYTES, 1, bytes per input beat; legal values 1, 2, 4 (elaboration error otherwise).
- CNT_WIDTH, 61, message byte-counter width; bit length = count<<3, emitted as 64 bits zero-extended.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_data  in  8*IN_BYTES  input bytes; byte 0 in bits [8*IN_BYTES-1 -: 8] is first in message order
- in_valid  in  1  input beat valid
- in_last  in  1  beat is last of message; qualified by in_valid
- in_nbytes  in  $clog2(IN_BYTES)+1  valid bytes on last beat, 0..IN_BYTES; 0 allowed (empty tail or empty message); ignored when in_last=0 (all bytes valid)
- in_ready  out  1  input beat accepted when in_valid && in_ready
- out_word  out  32  big-endian message schedule word W[t]
- out_valid  out  1  out_word valid; held with stable data until out_ready
- out_ready  in  1  core accepts word
- out_idx  out  4  word index within block, 0..15
- out_first  out  1  word belongs to first block of message (core loads IV)
- out_blk_end  out  1  out_idx==15 (core runs compression)
- out_msg_end  out  1  last word of final block (digest valid after this block)

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, in_ready=0, out_word=0, out_idx=0, all flags 0.
  - Byte counter, word accumulator, byte offset and state are cleared; any message in flight is discarded.
  - First cycle after reset: state IDLE, in_ready=1.
- Output register: single 32-bit stage. A word is loaded when the accumulator fills and either out_valid=0 or out_ready=1 that cycle. out_idx increments mod 16 per accepted word.
- in_ready = state in {IDLE,DATA} && (!out_valid || out_ready). No combinational path from in_valid to in_ready.
- Packing: bytes fill the accumulator MSB-first. Beats never straddle words (IN_BYTES divides 4). IN_BYTES=4 sustains one word per cycle with out_ready held high.
- Byte counter adds accepted valid bytes and wraps modulo 2^CNT_WIDTH.
- FSM:
  - IDLE: first accepted beat -> DATA; out_first asserted for words until first out_blk_end accepted.
  - DATA: accumulate. An accepted in_last beat -> PAD80.
  - PAD80: insert 0x80 at current byte offset, zero-fill rest of word, emit -> ZERO.
    - Emission occurs even if offset=0; the word is then 0x80000000.
  - ZERO: emit 0x00000000 until out_idx==14 is next to load -> LENHI. This crosses into an extra block when PAD80 word landed at idx 14 or 15.
  - LENHI: emit bitlen[63:32] -> LENLO.
  - LENLO: emit bitlen[31:0] with out_blk_end=1, out_msg_end=1 -> IDLE once accepted; counter cleared.
- Two-block rule: a message with len mod 64 >= 56 bytes produces one extra block. len mod 64 == 0 (including empty) still gets a pad block.
- Back-pressure: out_valid high with out_ready low holds out_word, flags, out_idx and state unchanged. in_ready=0.
- in_valid with in_ready=0: beat not consumed; source must hold it.

Optional Feature:
- Macro MP_ABORT_EN.
- Defined:
  - Adds input port in_abort (1 bit).
  - in_abort=1 in any state at a clock edge: drops the partial word and pending output word. out_valid=0 next cycle, counter cleared, -> IDLE.
  - in_abort has priority over a simultaneous in_valid beat, which is dropped.
- Not defined: no port; a message, once started, always completes padding.

Test Plan:
- "abc", IN_BYTES=1, out_ready=1 -> 16 words: 0x61626380, 13x 0x00000000, 0x00000000, 0x00000018. out_first on all, out_blk_end/out_msg_end on idx 15.
- Empty message (single beat in_last=1, in_nbytes=0) -> 0x80000000, 15x 0x00000000. Last word 0x00000000 with out_msg_end.
- 55 bytes of 0x41 -> one block: word13=0x41414180, word15=0x000001B8.
- 56 bytes of 0x41 -> 32 words:
  - word14=0x80000000, word15=0 with out_blk_end=1, out_msg_end=0.
  - Second block out_first=0, word31=0x000001C0 with out_msg_end.
- IN_BYTES=4, 64-byte message, out_ready toggled 1-0-1 every cycle -> no word lost or duplicated; out_word stable while stalled; 32 words, final 0x00000200.
- rst_n low for one cycle mid-DATA of a 10-byte message, then "abc" sent -> output identical to scenario 1. With MP_ABORT_EN, in_abort mid-message gives the same result.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 packer/padder: bytes in, big-endian words out with 0x80/zero/bit-length padding; in_abort via `define MP_ABORT_EN.
// Latency: one cycle from a filled accumulator (or pad/length step) to out_valid.
// Backpressure: a stalled output word holds everything and drops in_ready; input beats are never consumed without room.
module sha256_msg_padder #(
  parameter int IN_BYTES  = 1,
  parameter int CNT_WIDTH = 61
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [8*IN_BYTES-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [$clog2(IN_BYTES):0] in_nbytes,
`ifdef MP_ABORT_EN
  input  logic                      in_abort,
`endif
  output logic                      in_ready,
  output logic [31:0]               out_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_idx,
  output logic                      out_first,
  output logic                      out_blk_end,
  output logic                      out_msg_end
);

  if (IN_BYTES != 1 && IN_BYTES != 2 && IN_BYTES != 4) begin : g_bad_in_bytes
    $error("sha256_msg_padder: IN_BYTES must be 1, 2 or 4");
  end

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DATA  = 3'd1;
  localparam logic [2:0] PAD80 = 3'd2;
  localparam logic [2:0] ZERO  = 3'd3;
  localparam logic [2:0] LENHI = 3'd4;
  localparam logic [2:0] LENLO = 3'd5;

  logic [2:0]           state;
  logic [31:0]          acc;
  logic [1:0]           off;
  logic [CNT_WIDTH-1:0] cnt;
  logic [3:0]           widx;
  logic                 first_blk;

  logic                 can_load;
  logic                 in_fire;
  logic [2:0]           nb_eff;
  logic [2:0]           off_fill;
  logic [31:0]          acc_fill;
  logic [31:0]          pad_word;
  logic [63:0]          bitlen;
  logic                 ld;
  logic [31:0]          ld_word;
  logic                 ld_msg_end;

  assign can_load = !out_valid || out_ready;
  assign in_ready = rst_n && (state == IDLE || state == DATA) && can_load;
  assign in_fire  = in_valid && in_ready;
  assign nb_eff   = in_last ? 3'(in_nbytes) : 3'(IN_BYTES);
  assign off_fill = {1'b0, off} + nb_eff;
  assign pad_word = acc | (32'h8000_0000 >> {off, 3'b000});
  assign bitlen   = 64'(cnt) << 3;

  // Beats never straddle words, so valid bytes always land inside the current word.
  always_comb begin
    acc_fill = acc;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (i < int'(nb_eff) && int'(off) + i < 4)
        acc_fill[8*(3-int'(off)-i) +: 8] = in_data[8*(IN_BYTES-1-i) +: 8];
    end
  end

  always_comb begin
    ld         = 1'b0;
    ld_word    = 32'h0;
    ld_msg_end = 1'b0;
    case (state)
      IDLE, DATA: begin
        ld      = in_fire && (off_fill == 3'd4);
        ld_word = acc_fill;
      end
      PAD80: begin
        ld      = can_load;
        ld_word = pad_word;
      end
      ZERO:  ld = can_load;
      LENHI: begin
        ld      = can_load;
        ld_word = bitlen[63:32];
      end
      LENLO: begin
        ld         = can_load;
        ld_word    = bitlen[31:0];
        ld_msg_end = 1'b1;
      end
      default: ld = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= 32'h0;
      off         <= 2'd0;
      cnt         <= '0;
      widx        <= 4'd0;
      first_blk   <= 1'b1;
      out_valid   <= 1'b0;
      out_word    <= 32'h0;
      out_idx     <= 4'd0;
      out_first   <= 1'b0;
      out_blk_end <= 1'b0;
      out_msg_end <= 1'b0;
    end
`ifdef MP_ABORT_EN
    else if (in_abort) begin
      state     <= IDLE;
      acc       <= 32'h0;
      off       <= 2'd0;
      cnt       <= '0;
      widx      <= 4'd0;
      first_blk <= 1'b1;
      out_valid <= 1'b0;
    end
`endif
    else begin
      if (ld) begin
        out_valid   <= 1'b1;
        out_word    <= ld_word;
        out_idx     <= widx;
        out_first   <= first_blk;
        out_blk_end <= (widx == 4'd15);
        out_msg_end <= ld_msg_end;
        widx        <= widx + 4'd1;
        if (widx == 4'd15) first_blk <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE, DATA: begin
          if (in_fire) begin
            cnt   <= cnt + CNT_WIDTH'(nb_eff);
            state <= in_last ? PAD80 : DATA;
            if (off_fill == 3'd4) begin
              acc <= 32'h0;
              off <= 2'd0;
            end else begin
              acc <= acc_fill;
              off <= off_fill[1:0];
            end
          end
        end
        PAD80: begin
          if (can_load) begin
            acc   <= 32'h0;
            off   <= 2'd0;
            state <= (widx == 4'd13) ? LENHI : ZERO;
          end
        end
        // Leaves ZERO once index 14 is the next to load, possibly in a following block.
        ZERO: begin
          if (can_load && widx == 4'd13) state <= LENHI;
        end
        LENHI: begin
          if (can_load) state <= LENLO;
        end
        LENLO: begin
          if (can_load) begin
            state     <= IDLE;
            cnt       <= '0;
            first_blk <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
